// File: rtl/echo_meter.sv
// ============================================================================
// Module   : echo_meter
// Purpose  : Receive-side companion to the ultrasonic trigger generator.
//            Arms on the falling edge of each trigger pulse, times the
//            returning echo pulse in whole microseconds, converts the width
//            to millimetres and reports it with a one-cycle valid strobe, or
//            a one-cycle timeout strobe when no echo arrives or the echo
//            never ends.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TICK_DIV   - clk cycles per microsecond (>= 2)
//   TIMEOUT_US - microsecond limit for both the wait and echo-high phases
//                (<= 65535)
// Ports
//   clk      in   1   system clock (100 MHz PLL)
//   rst_n    in   1   asynchronous active-low reset
//   trig     in   1   trigger pulse, asynchronous to clk
//   echo     in   1   sensor echo pin, asynchronous to clk
//   width_us out  16  last valid echo width in microseconds
//   dist_mm  out  16  last valid distance in millimetres
//   valid    out  1   one-cycle strobe, width_us/dist_mm new in same cycle
//   timeout  out  1   one-cycle strobe on timeout
//   busy     out  1   high whenever a measurement is in progress
// ============================================================================
`default_nettype none

module echo_meter #(
  parameter int TICK_DIV   = 100,
  parameter int TIMEOUT_US = 30000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  input  logic        echo,
  output logic [15:0] width_us,
  output logic [15:0] dist_mm,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int          c_tick_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_tick_w-1:0] c_tick_max = c_tick_w'(TICK_DIV - 1);
  localparam logic [15:0] c_timeout  = 16'(TIMEOUT_US);
  // 0.17149 mm/us in Q16: speed of sound 343 m/s, halved for the round trip
  localparam logic [29:0] c_mm_per_us_q16 = 30'd11239;

  localparam logic [1:0] c_st_idle      = 2'd0;
  localparam logic [1:0] c_st_wait_rise = 2'd1;
  localparam logic [1:0] c_st_measure   = 2'd2;
  localparam logic [1:0] c_st_done      = 2'd3;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic                r_trig_meta;
  logic                r_trig_sync;
  logic                r_trig_hist;
  logic                r_echo_meta;
  logic                r_echo_sync;
  logic                r_echo_hist;

  logic                w_trig_fall;
  logic                w_echo_rise;
  logic                w_echo_fall;

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;

  logic [c_tick_w-1:0] r_tick_cnt;
  logic [15:0]         r_us_cnt;
  logic                w_wrap;
  logic [15:0]         w_us_next;
  logic                w_limit;

  logic                w_cnt_run;
  logic                w_load;
  logic                w_timeout_evt;
  logic [29:0]         w_product;

  // --------------------------------------------------------------------------
  // Input synchronizers: two flops for metastability, one history flop for
  // edge detection. Both inputs see identical latency, so the measured width
  // matches the pad-level width.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_meta <= 1'b0;
      r_trig_sync <= 1'b0;
      r_trig_hist <= 1'b0;
      r_echo_meta <= 1'b0;
      r_echo_sync <= 1'b0;
      r_echo_hist <= 1'b0;
    end else begin
      r_trig_meta <= trig;
      r_trig_sync <= r_trig_meta;
      r_trig_hist <= r_trig_sync;
      r_echo_meta <= echo;
      r_echo_sync <= r_echo_meta;
      r_echo_hist <= r_echo_sync;
    end
  end

  assign w_trig_fall = ~r_trig_sync &  r_trig_hist;
  assign w_echo_rise =  r_echo_sync & ~r_echo_hist;
  assign w_echo_fall = ~r_echo_sync &  r_echo_hist;

  // --------------------------------------------------------------------------
  // Microsecond timebase.
  // w_us_next is the count including the tick of the current cycle; latching
  // it (rather than r_us_cnt) makes an echo high for N cycles report exactly
  // floor(N / TICK_DIV).
  // --------------------------------------------------------------------------
  assign w_wrap    = (r_tick_cnt == c_tick_max);
  assign w_us_next = r_us_cnt + 16'(w_wrap);
  assign w_limit   = w_wrap && (w_us_next == c_timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_us_cnt   <= '0;
    end else if (w_cnt_run) begin
      r_tick_cnt <= w_wrap ? '0 : r_tick_cnt + c_tick_w'(1);
      r_us_cnt   <= w_us_next;
    end else begin
      // Held at zero outside the timed states, so every entry to WAIT_RISE
      // or MEASURE starts from a clean count.
      r_tick_cnt <= '0;
      r_us_cnt   <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. Echo edges only matter once armed; trig edges
  // only matter in IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_trig_fall) begin
          w_state_next = c_st_wait_rise;
        end
      end
      c_st_wait_rise: begin
        if (w_echo_rise) begin
          w_state_next = c_st_measure;
        end else if (w_limit) begin
          w_state_next = c_st_idle;
        end
      end
      c_st_measure: begin
        // A fall coinciding with the limit still yields a measurement.
        if (w_echo_fall) begin
          w_state_next = c_st_done;
        end else if (w_limit) begin
          w_state_next = c_st_idle;
        end
      end
      c_st_done: begin
        w_state_next = c_st_idle;
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    busy          = (r_state != c_st_idle);
    valid         = (r_state == c_st_done);
    w_cnt_run     = 1'b0;
    w_load        = 1'b0;
    w_timeout_evt = 1'b0;
    case (r_state)
      c_st_wait_rise: begin
        w_cnt_run     = (w_state_next == c_st_wait_rise);
        w_timeout_evt = ~w_echo_rise & w_limit;
      end
      c_st_measure: begin
        w_cnt_run     = (w_state_next == c_st_measure);
        w_load        = w_echo_fall;
        w_timeout_evt = ~w_echo_fall & w_limit;
      end
      default: begin
        w_cnt_run     = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Distance: width * 0.17149, as a 30-bit Q16 product truncated to integer.
  // Computed from the same value being latched into width_us so both outputs
  // update on the same edge.
  // --------------------------------------------------------------------------
  assign w_product = 30'(w_us_next) * c_mm_per_us_q16;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_us <= '0;
      dist_mm  <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= w_timeout_evt;
      if (w_load) begin
        width_us <= w_us_next;
        dist_mm  <= 16'(w_product >> 16);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_echo_meter.sv
// ============================================================================
// Module   : tb_echo_meter
// Purpose  : Directed self-checking bench for echo_meter. Uses TICK_DIV=2 and
//            TIMEOUT_US=6000 so every scenario stays short; widths are
//            quoted in microseconds, so the distance values are the same as
//            at full rate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_echo_meter;

  localparam int TICK_DIV   = 2;
  localparam int TIMEOUT_US = 6000;
  localparam int TO_CYC     = TICK_DIV * TIMEOUT_US;  // 12000 clk
  // trig/echo change -> armed state: 3 edges of synchronizer + edge detect
  localparam int SYNC_LAT   = 3;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic        echo;
  logic [15:0] width_us;
  logic [15:0] dist_mm;
  logic        valid;
  logic        timeout;
  logic        busy;

  int n_vec;
  int n_err;
  int cyc;
  int n_valid;
  int n_timeout;
  bit both_seen;

  echo_meter #(
    .TICK_DIV   (TICK_DIV),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig     (trig),
    .echo     (echo),
    .width_us (width_us),
    .dist_mm  (dist_mm),
    .valid    (valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) n_valid <= n_valid + 1;
    if (timeout === 1'b1) n_timeout <= n_timeout + 1;
    if (valid === 1'b1 && timeout === 1'b1) both_seen <= 1'b1;
  end

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic arm(output int t_fall);
    @(negedge clk); trig = 1'b1;
    repeat (5) @(negedge clk);
    trig = 1'b0;
    t_fall = cyc;
    repeat (4) @(negedge clk);
  endtask

  task automatic echo_pulse(input int n);
    @(negedge clk); echo = 1'b1;
    repeat (n) @(negedge clk);
    echo = 1'b0;
  endtask

  task automatic wait_strobe(input int max_cyc, output bit got_v, output bit got_t);
    got_v = 1'b0;
    got_t = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (valid === 1'b1) got_v = 1'b1;
      if (timeout === 1'b1) got_t = 1'b1;
      if (got_v || got_t) break;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0; trig = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (width_us !== 16'd0) begin n_err++; $display("FAIL reset_width got=%0d exp=0", width_us); end
    n_vec++; if (dist_mm !== 16'd0) begin n_err++; $display("FAIL reset_dist got=%0d exp=0", dist_mm); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++; if (n_valid + n_timeout != 0) begin n_err++; $display("FAIL reset_idle_strobes got=%0d exp=0", n_valid + n_timeout); end
  endtask

  task automatic test_nominal;
    int t; bit gv, gt; int nv0;
    nv0 = n_valid;
    arm(t);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL nominal_busy_armed got=%b exp=1", busy); end
    echo_pulse(1000 * TICK_DIV);
    wait_strobe(20, gv, gt);
    n_vec++; if (gv !== 1'b1 || gt !== 1'b0) begin n_err++; $display("FAIL nominal_strobe got v=%b t=%b exp v=1 t=0", gv, gt); end
    n_vec++; if (width_us !== 16'd1000) begin n_err++; $display("FAIL nominal_width got=%0d exp=1000", width_us); end
    n_vec++; if (dist_mm !== 16'd171) begin n_err++; $display("FAIL nominal_dist got=%0d exp=171", dist_mm); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL nominal_busy_at_valid got=%b exp=1", busy); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || valid !== 1'b0) begin n_err++; $display("FAIL nominal_after_valid got busy=%b valid=%b exp 0 0", busy, valid); end
    repeat (10) @(negedge clk);
    n_vec++; if (n_valid != nv0 + 1) begin n_err++; $display("FAIL nominal_single_valid got=%0d exp=%0d", n_valid - nv0, 1); end
  endtask

  task automatic test_truncation;
    int t; bit gv, gt;
    arm(t);
    echo_pulse(1000 * TICK_DIV + TICK_DIV - 1);
    wait_strobe(20, gv, gt);
    n_vec++; if (gv !== 1'b1 || width_us !== 16'd1000) begin n_err++; $display("FAIL trunc_width got v=%b w=%0d exp v=1 w=1000", gv, width_us); end
    repeat (3) @(negedge clk);
    arm(t);
    echo_pulse(5831 * TICK_DIV);
    wait_strobe(20, gv, gt);
    n_vec++; if (gv !== 1'b1 || width_us !== 16'd5831) begin n_err++; $display("FAIL range_width got v=%b w=%0d exp v=1 w=5831", gv, width_us); end
    n_vec++; if (dist_mm !== 16'd999) begin n_err++; $display("FAIL range_dist got=%0d exp=999", dist_mm); end
    repeat (3) @(negedge clk);
    arm(t);
    echo_pulse(13);  // 6.5 us -> 6 us, 6*11239>>16 = 1 mm
    wait_strobe(20, gv, gt);
    n_vec++; if (gv !== 1'b1 || width_us !== 16'd6 || dist_mm !== 16'd1) begin n_err++; $display("FAIL short_echo got v=%b w=%0d d=%0d exp v=1 w=6 d=1", gv, width_us, dist_mm); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_no_echo;
    int t; int dt; bit gv, gt;
    arm(t);
    wait_strobe(TO_CYC + 100, gv, gt);
    dt = cyc - t - SYNC_LAT;
    n_vec++; if (gt !== 1'b1 || gv !== 1'b0) begin n_err++; $display("FAIL noecho_strobe got v=%b t=%b exp v=0 t=1", gv, gt); end
    n_vec++; if (dt < TO_CYC - 2 || dt > TO_CYC + 2) begin n_err++; $display("FAIL noecho_time got=%0d exp=%0d+-2", dt, TO_CYC); end
    n_vec++; if (width_us !== 16'd6 || dist_mm !== 16'd1) begin n_err++; $display("FAIL noecho_retain got w=%0d d=%0d exp w=6 d=1", width_us, dist_mm); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL noecho_busy got=%b exp=0", busy); end
    @(negedge clk);
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL noecho_one_cycle got=%b exp=0", timeout); end
  endtask

  task automatic test_stuck_echo;
    int t; int dt; int nv0; bit gv, gt;
    nv0 = n_valid;
    arm(t);
    @(negedge clk); echo = 1'b1; t = cyc;
    wait_strobe(TO_CYC + 100, gv, gt);
    dt = cyc - t - SYNC_LAT;
    n_vec++; if (gt !== 1'b1 || gv !== 1'b0) begin n_err++; $display("FAIL stuck_strobe got v=%b t=%b exp v=0 t=1", gv, gt); end
    n_vec++; if (dt < TO_CYC - 2 || dt > TO_CYC + 2) begin n_err++; $display("FAIL stuck_time got=%0d exp=%0d+-2", dt, TO_CYC); end
    echo = 1'b0;
    repeat (10) @(negedge clk);
    n_vec++; if (n_valid != nv0 || busy !== 1'b0) begin n_err++; $display("FAIL stuck_no_valid got nvalid=%0d busy=%b exp 0 0", n_valid - nv0, busy); end
  endtask

  task automatic test_ignored;
    int t; int nv0; int nt0; bit busy_seen; bit gv, gt;
    // echo while idle
    nv0 = n_valid; nt0 = n_timeout; busy_seen = 1'b0;
    @(negedge clk); echo = 1'b1;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (busy !== 1'b0) busy_seen = 1'b1; end
    echo = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (busy !== 1'b0) busy_seen = 1'b1; end
    n_vec++; if (busy_seen || n_valid != nv0 || n_timeout != nt0) begin n_err++; $display("FAIL idle_echo got busy=%b strobes=%0d exp 0 0", busy_seen, n_valid - nv0 + n_timeout - nt0); end
    // second trig during MEASURE
    arm(t);
    @(negedge clk); echo = 1'b1;
    repeat (500) @(negedge clk);
    trig = 1'b1;
    repeat (5) @(negedge clk);
    trig = 1'b0;
    repeat (1000 * TICK_DIV - 505) @(negedge clk);
    echo = 1'b0;
    wait_strobe(20, gv, gt);
    n_vec++; if (gv !== 1'b1 || width_us !== 16'd1000 || dist_mm !== 16'd171) begin n_err++; $display("FAIL retrig_measure got v=%b w=%0d d=%0d exp v=1 w=1000 d=171", gv, width_us, dist_mm); end
    repeat (10) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL retrig_no_rearm got busy=%b exp=0", busy); end
    // echo already high at arm
    nv0 = n_valid;
    @(negedge clk); echo = 1'b1;
    repeat (10) @(negedge clk);
    arm(t);
    repeat (20) @(negedge clk);
    echo = 1'b0;
    repeat (20) @(negedge clk);
    n_vec++; if (n_valid != nv0 || busy !== 1'b1) begin n_err++; $display("FAIL high_at_arm_wait got nvalid=%0d busy=%b exp 0 1", n_valid - nv0, busy); end
    echo_pulse(500 * TICK_DIV);
    wait_strobe(20, gv, gt);
    n_vec++; if (gv !== 1'b1 || width_us !== 16'd500 || dist_mm !== 16'd85) begin n_err++; $display("FAIL high_at_arm got v=%b w=%0d d=%0d exp v=1 w=500 d=85", gv, width_us, dist_mm); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int t; int nv0; int nt0; bit gv, gt;
    arm(t);
    @(negedge clk); echo = 1'b1;
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (width_us !== 16'd0 || dist_mm !== 16'd0) begin n_err++; $display("FAIL async_reset_data got w=%0d d=%0d exp 0 0", width_us, dist_mm); end
    n_vec++; if (valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL async_reset_ctrl got v=%b t=%b b=%b exp 0 0 0", valid, timeout, busy); end
    echo = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    nv0 = n_valid; nt0 = n_timeout;
    repeat (60) @(negedge clk);
    n_vec++; if (n_valid != nv0 || n_timeout != nt0 || busy !== 1'b0) begin n_err++; $display("FAIL post_reset_quiet got strobes=%0d busy=%b exp 0 0", n_valid - nv0 + n_timeout - nt0, busy); end
    arm(t);
    echo_pulse(100 * TICK_DIV);
    wait_strobe(20, gv, gt);
    n_vec++; if (gv !== 1'b1 || width_us !== 16'd100 || dist_mm !== 16'd17) begin n_err++; $display("FAIL post_reset_measure got v=%b w=%0d d=%0d exp v=1 w=100 d=17", gv, width_us, dist_mm); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_exclusive;
    n_vec++; if (both_seen !== 1'b0) begin n_err++; $display("FAIL valid_timeout_overlap got=%b exp=0", both_seen); end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    n_valid = 0; n_timeout = 0; both_seen = 1'b0;
    test_reset;
    test_nominal;
    test_truncation;
    test_no_echo;
    test_stuck_echo;
    test_ignored;
    test_reset_mid;
    test_exclusive;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
